// File: rtl/cell_alu_pipe_if.sv
// Operand/result handshake bundle for cell_alu_pipe: operand side (in_*) and
// result side (out_*), each with its own valid/ready pair.
interface cell_alu_pipe_if #(
   parameter int OPCODE_WIDTH  = 4,
   parameter int CHANNEL_WIDTH = 8,
   parameter int CHANNEL_NUM   = 3,
   parameter int CELL_N        = 3
);
   localparam int PIXEL_DEPTH = CHANNEL_WIDTH * CHANNEL_NUM;
   localparam int CELL_DEPTH  = PIXEL_DEPTH * CELL_N * CELL_N;

   logic                     in_valid;
   logic                     in_ready;
   logic [OPCODE_WIDTH-1:0]  in_opcode;
   logic [CELL_DEPTH-1:0]    in_cell_a;
   logic [CELL_DEPTH-1:0]    in_cell_b;
   logic [CHANNEL_WIDTH-1:0] in_user;
   logic                     out_valid;
   logic                     out_ready;
   logic [PIXEL_DEPTH-1:0]   out_pixel;
   logic                     out_err;

   modport master (
      output in_valid, in_opcode, in_cell_a, in_cell_b, in_user, out_ready,
      input  in_ready, out_valid, out_pixel, out_err
   );

   modport slave (
      input  in_valid, in_opcode, in_cell_a, in_cell_b, in_user, out_ready,
      output in_ready, out_valid, out_pixel, out_err
   );
endinterface

// File: rtl/cell_alu_pipe.sv
// Handshaked cell ALU: pointwise ops on centre pixels, multi-cycle exact AVG.
// Define CELL_ALU_SATURATE_EN to clamp ADD/ADDI/MULT/MULTI/SUB/SUBI instead of wrapping.
module cell_alu_pipe #(
   parameter int OPCODE_WIDTH  = 4,
   parameter int CHANNEL_WIDTH = 8,
   parameter int CHANNEL_NUM   = 3,
   parameter int CELL_N        = 3
) (
   input logic            clk,
   input logic            reset_n,
   cell_alu_pipe_if.slave bus
);
   localparam int W           = CHANNEL_WIDTH;
   localparam int PIXEL_DEPTH = W * CHANNEL_NUM;
   localparam int CELL_DEPTH  = PIXEL_DEPTH * CELL_N * CELL_N;
   localparam int NN          = CELL_N * CELL_N;
   localparam int CENTER      = (NN - 1) / 2;
   localparam int ACC_W       = W + $clog2(NN);
   localparam int IDX_W       = (NN > 1) ? $clog2(NN) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} stateT;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_ADD   = OPCODE_WIDTH'(0),
      OP_ADDI  = OPCODE_WIDTH'(1),
      OP_SUB   = OPCODE_WIDTH'(2),
      OP_SUBI  = OPCODE_WIDTH'(3),
      OP_MULT  = OPCODE_WIDTH'(4),
      OP_MULTI = OPCODE_WIDTH'(5),
      OP_DIV2  = OPCODE_WIDTH'(6),
      OP_INV   = OPCODE_WIDTH'(7),
      OP_AND   = OPCODE_WIDTH'(8),
      OP_OR    = OPCODE_WIDTH'(9),
      OP_NOR   = OPCODE_WIDTH'(10),
      OP_AVG   = OPCODE_WIDTH'(11)
   } opcodeT;

   stateT                                 state;
   logic [OPCODE_WIDTH-1:0]               opReg;
   logic [CELL_DEPTH-1:0]                 cellA;
   logic [PIXEL_DEPTH-1:0]                bCenter;
   logic [W-1:0]                          userReg;
   logic [CHANNEL_NUM-1:0][ACC_W-1:0]     acc;
   logic [IDX_W-1:0]                      idx;
   logic                                  inReady;
   logic                                  outValid;
   logic [PIXEL_DEPTH-1:0]                outPixel;
   logic                                  outErr;

   logic [PIXEL_DEPTH-1:0]                pointPixel;
   logic                                  pointErr;
   logic [CHANNEL_NUM-1:0][ACC_W-1:0]     accSum;
   logic [PIXEL_DEPTH-1:0]                avgPixel;

   // Only the centre pixel of cell B ever feeds an operation.
   logic unusedCellB;
   assign unusedCellB = ^bus.in_cell_b;

   function automatic logic [W-1:0] chanOp(
      input logic [OPCODE_WIDTH-1:0] op,
      input logic [W-1:0]            a,
      input logic [W-1:0]            b,
      input logic [W-1:0]            u
   );
      logic [W-1:0] res;
`ifdef CELL_ALU_SATURATE_EN
      logic [W:0]     sum;
      logic [2*W-1:0] prod;
      sum  = '0;
      prod = '0;
`endif
      res = a;
      case (op)
`ifdef CELL_ALU_SATURATE_EN
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[W] ? '1 : sum[W-1:0];
         end
         OP_ADDI: begin
            sum = {1'b0, a} + {1'b0, u};
            res = sum[W] ? '1 : sum[W-1:0];
         end
         OP_SUB:  res = (a < b) ? '0 : a - b;
         OP_SUBI: res = (a < u) ? '0 : a - u;
         OP_MULT: begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            res  = (|prod[2*W-1:W]) ? '1 : prod[W-1:0];
         end
         OP_MULTI: begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, u};
            res  = (|prod[2*W-1:W]) ? '1 : prod[W-1:0];
         end
`else
         OP_ADD:   res = a + b;
         OP_ADDI:  res = a + u;
         OP_SUB:   res = a - b;
         OP_SUBI:  res = a - u;
         OP_MULT:  res = a * b;
         OP_MULTI: res = a * u;
`endif
         OP_DIV2:  res = a >> 1;
         OP_INV:   res = ~a;
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         OP_NOR:   res = ~(a | b);
         default:  res = a;
      endcase
      return res;
   endfunction

   // AVG consumes cell A from the low pixel upward; the register is shifted
   // each accumulate cycle so pixel idx always sits at slot 0.
   always_comb begin
      pointPixel = '0;
      accSum     = '0;
      avgPixel   = '0;
      pointErr   = (opReg > OP_AVG);
      for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
         pointPixel[c*W +: W] = chanOp(opReg, cellA[CENTER*PIXEL_DEPTH + c*W +: W],
                                       bCenter[c*W +: W], userReg);
         accSum[c]            = acc[c] + ACC_W'(cellA[c*W +: W]);
         avgPixel[c*W +: W]   = W'(accSum[c] / ACC_W'(NN));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         opReg    <= '0;
         cellA    <= '0;
         bCenter  <= '0;
         userReg  <= '0;
         acc      <= '0;
         idx      <= '0;
         inReady  <= 1'b1;
         outValid <= 1'b0;
         outPixel <= '0;
         outErr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && inReady) begin
                  opReg   <= bus.in_opcode;
                  cellA   <= bus.in_cell_a;
                  bCenter <= bus.in_cell_b[CENTER*PIXEL_DEPTH +: PIXEL_DEPTH];
                  userReg <= bus.in_user;
                  acc     <= '0;
                  idx     <= '0;
                  inReady <= 1'b0;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               if (opReg == OP_AVG) begin
                  acc   <= accSum;
                  cellA <= cellA >> PIXEL_DEPTH;
                  idx   <= idx + 1'b1;
                  if (idx == IDX_W'(NN - 1)) begin
                     outPixel <= avgPixel;
                     outErr   <= 1'b0;
                     outValid <= 1'b1;
                     state    <= DONE;
                  end
               end else begin
                  outPixel <= pointPixel;
                  outErr   <= pointErr;
                  outValid <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  outValid <= 1'b0;
                  inReady  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_pixel = outPixel;
   assign bus.out_err   = outErr;
endmodule

// File: tb/tb_cell_alu_pipe.sv
// Randomised bench for cell_alu_pipe against an arithmetic reference model.
// Honours CELL_ALU_SATURATE_EN the same way the design does.
module tb_cell_alu_pipe;
   localparam int OW     = 4;
   localparam int W      = 8;
   localparam int C      = 3;
   localparam int N      = 3;
   localparam int PD     = W * C;
   localparam int CD     = PD * N * N;
   localparam int NN     = N * N;
   localparam int CENTER = (NN - 1) / 2;
   localparam int MAXV   = (1 << W) - 1;

   logic clk    = 1'b0;
   logic resetN = 1'b1;
   int   nChecks = 0;
   int   nFails  = 0;

   cell_alu_pipe_if #(.OPCODE_WIDTH(OW), .CHANNEL_WIDTH(W), .CHANNEL_NUM(C), .CELL_N(N)) bus ();

   cell_alu_pipe #(.OPCODE_WIDTH(OW), .CHANNEL_WIDTH(W), .CHANNEL_NUM(C), .CELL_N(N)) dut (
      .clk     (clk),
      .reset_n (resetN),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns {err, pixel}.
   function automatic logic [PD:0] refModel(input int op, input logic [CD-1:0] a,
                                            input logic [CD-1:0] b, input logic [W-1:0] u);
      logic [PD-1:0] pix;
      logic          err;
      int            x, y, uu, r;
      pix = '0;
      err = 1'b0;
      uu  = u;
      for (int c = 0; c < C; c++) begin
         x = a[CENTER*PD + c*W +: W];
         y = b[CENTER*PD + c*W +: W];
         case (op)
            0:  r = x + y;
            1:  r = x + uu;
            2:  r = x - y;
            3:  r = x - uu;
            4:  r = x * y;
            5:  r = x * uu;
            6:  r = x / 2;
            7:  r = MAXV - x;
            8:  r = x & y;
            9:  r = x | y;
            10: r = MAXV - (x | y);
            11: begin
               r = 0;
               for (int p = 0; p < NN; p++) r += a[p*PD + c*W +: W];
               r = r / NN;
            end
            default: begin
               r   = x;
               err = 1'b1;
            end
         endcase
`ifdef CELL_ALU_SATURATE_EN
         if ((op == 0 || op == 1 || op == 4 || op == 5) && r > MAXV) r = MAXV;
         if ((op == 2 || op == 3) && r < 0) r = 0;
`endif
         pix[c*W +: W] = W'(r & MAXV);
      end
      return {err, pix};
   endfunction

   function automatic logic [CD-1:0] randCell();
      logic [CD-1:0] v;
      for (int i = 0; i < CD; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // Caller must be at a negedge; returns at the negedge after the output handshake.
   task automatic runOp(input string tag, input int op, input logic [CD-1:0] a,
                        input logic [CD-1:0] b, input logic [W-1:0] u, input int hold,
                        output logic [PD-1:0] gotPix, output logic gotErr);
      logic [PD:0] exp;
      int          lat;
      int          expLat;
      exp    = refModel(op, a, b, u);
      expLat = (op == 11) ? NN : 1;
      checkVal({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid  = 1'b1;
      bus.in_opcode = OW'(op);
      bus.in_cell_a = a;
      bus.in_cell_b = b;
      bus.in_user   = u;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_opcode = OW'($urandom);
      bus.in_cell_a = randCell();
      bus.in_cell_b = randCell();
      bus.in_user   = W'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         checkVal({tag, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
         @(negedge clk);
         lat++;
      end
      gotPix = bus.out_pixel;
      gotErr = bus.out_err;
      checkVal({tag, " latency"}, 64'(lat), 64'(expLat));
      checkVal({tag, " pixel"}, 64'(gotPix), 64'(exp[PD-1:0]));
      checkVal({tag, " err"}, 64'(gotErr), 64'(exp[PD]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkVal({tag, " held pixel"}, 64'(bus.out_pixel), 64'(exp[PD-1:0]));
         checkVal({tag, " held valid"}, 64'(bus.out_valid), 64'd1);
         checkVal({tag, " held in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkVal({tag, " valid drop"}, 64'(bus.out_valid), 64'd0);
      checkVal({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CD-1:0] a, b;
      logic [PD-1:0] pix;
      logic          err;

      bus.in_valid  = 1'b0;
      bus.in_opcode = '0;
      bus.in_cell_a = '0;
      bus.in_cell_b = '0;
      bus.in_user   = '0;
      bus.out_ready = 1'b0;

      #1 resetN = 1'b0;
      repeat (2) @(negedge clk);
      checkVal("reset in_ready", 64'(bus.in_ready), 64'd1);
      checkVal("reset out_valid", 64'(bus.out_valid), 64'd0);
      checkVal("reset out_pixel", 64'(bus.out_pixel), 64'd0);
      checkVal("reset out_err", 64'(bus.out_err), 64'd0);
      resetN = 1'b1;
      @(negedge clk);

      a = randCell(); a[CENTER*PD +: PD] = 24'h1020F0;
      b = randCell(); b[CENTER*PD +: PD] = 24'h010220;
      runOp("add", 0, a, b, 8'h00, 0, pix, err);
`ifdef CELL_ALU_SATURATE_EN
      checkVal("add const", 64'(pix), 64'h1122FF);
`else
      checkVal("add const", 64'(pix), 64'h112210);
`endif

      a = randCell(); a[CENTER*PD +: PD] = 24'h204080;
      runOp("subi", 3, a, randCell(), 8'h30, 0, pix, err);
`ifdef CELL_ALU_SATURATE_EN
      checkVal("subi const", 64'(pix), 64'h001050);
`else
      checkVal("subi const", 64'(pix), 64'hF01050);
`endif

      for (int p = 0; p < NN; p++) a[p*PD +: PD] = {8'h00, 8'hFF, 8'(p + 1)};
      runOp("avg", 11, a, randCell(), 8'h00, 0, pix, err);
      checkVal("avg const", 64'(pix), 64'h00FF05);

      runOp("bp sub", 2, randCell(), randCell(), 8'h00, 5, pix, err);
      a = randCell(); a[CENTER*PD +: PD] = 24'h102030;
      runOp("multi", 5, a, randCell(), 8'h02, 0, pix, err);
      checkVal("multi const", 64'(pix), 64'h204060);

      a = randCell(); a[CENTER*PD +: PD] = 24'hABCDEF;
      runOp("illegal", 13, a, randCell(), 8'h00, 0, pix, err);
      checkVal("illegal const", 64'(pix), 64'hABCDEF);
      checkVal("illegal err", 64'(err), 64'd1);
      a = randCell(); a[CENTER*PD +: PD] = 24'h00FF0F;
      runOp("inv", 7, a, randCell(), 8'h00, 0, pix, err);
      checkVal("inv const", 64'(pix), 64'hFF00F0);
      checkVal("inv err", 64'(err), 64'd0);

      // Reset while AVG is accumulating.
      bus.in_valid  = 1'b1;
      bus.in_opcode = OW'(11);
      bus.in_cell_a = randCell();
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      checkVal("mid reset out_valid", 64'(bus.out_valid), 64'd0);
      checkVal("mid reset out_pixel", 64'(bus.out_pixel), 64'd0);
      checkVal("mid reset in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      checkVal("post reset in_ready", 64'(bus.in_ready), 64'd1);
      checkVal("post reset out_valid", 64'(bus.out_valid), 64'd0);
      a = randCell(); a[CENTER*PD +: PD] = 24'h010101;
      b = randCell(); b[CENTER*PD +: PD] = 24'h010101;
      runOp("post reset add", 0, a, b, 8'h00, 0, pix, err);
      checkVal("post reset add const", 64'(pix), 64'h020202);

      for (int t = 0; t < 120; t++) begin
         runOp("rand", $urandom_range(0, 15), randCell(), randCell(), W'($urandom),
               $urandom_range(0, 3), pix, err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule

// File: doc/cell_alu_pipe.md
Name: cell_alu_pipe

Overview:
- Parametrised, handshaked successor to the package-level cell functions.
- Accepts one cell operation per transaction: two cells of CELL_N x CELL_N pixels, one user immediate and an opcode. Returns one result pixel.
- Pointwise opcodes operate on the centre pixels. AVG is multi-cycle: it accumulates one pixel per cycle and then does an exact divide.
- Sits between the image line-buffer/cell extractor and the output image writer.

Parameters:
- OPCODE_WIDTH, 4, opcode field width
- CHANNEL_WIDTH, 8, bits per colour channel (W)
- CHANNEL_NUM, 3, channels per pixel (C)
- CELL_N, 3, cell edge length, odd, >=1 (N)
- Derived, not overridable:
  - PIXEL_DEPTH = W*C
  - CELL_DEPTH = PIXEL_DEPTH*N*N
  - CENTER = (N*N-1)/2

Ports:
- clk  in  1  Single clock, rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  Operand valid.
- in_ready  out  1  Block can accept operands.
- in_opcode  in  OPCODE_WIDTH  0 ADD, 1 ADDI, 2 SUB, 3 SUBI, 4 MULT, 5 MULTI, 6 DIV2, 7 INV, 8 AND, 9 OR, 10 NOR, 11 AVG.
- in_cell_a  in  CELL_DEPTH  Cell A. Pixel p sits at [p*PIXEL_DEPTH +: PIXEL_DEPTH]; channel c at [c*W +: W] within the pixel.
- in_cell_b  in  CELL_DEPTH  Cell B, same layout.
- in_user  in  W  Immediate for ADDI/SUBI/MULTI.
- out_valid  out  1  Result valid.
- out_ready  in  1  Consumer accepts the result.
- out_pixel  out  PIXEL_DEPTH  Result pixel.
- out_err  out  1  Illegal opcode flag, qualified by out_valid.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; in_ready=1; out_valid=0; out_pixel=0; out_err=0.
  - Accumulators and index are cleared.
  - A reset mid-transaction discards the transaction, with no partial output.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge k: latch opcode, both cells and in_user, go to EXEC.
  - After edge k, inputs are don't-care.
- EXEC:
  - in_ready=0.
  - Pointwise opcodes: result registered at edge k+1; go to DONE.
  - AVG:
    - Edges k+1..k+N*N each add pixel[idx] per channel into accumulators of width W+$clog2(N*N); idx counts 0..N*N-1.
    - At edge k+N*N the final channel value floor(sum/(N*N)) is registered into out_pixel; go to DONE.
    - The divide is exact, by a constant; no shift approximation.
  - Latency from accept to out_valid: 1 cycle for pointwise, N*N cycles for AVG.
- DONE:
  - out_valid=1; out_pixel and out_err held stable.
  - On out_valid&out_ready: out_valid drops at that edge, return to IDLE, in_ready=1 the following cycle.
  - Throughput is one transaction per 3 cycles (pointwise) at best.
- Per-channel arithmetic on the centre pixels a = A[CENTER], b = B[CENTER], u = in_user:
  - ADD a+b; ADDI a+u; SUB a-b; SUBI a-u.
  - MULT is the low W bits of the 2W product a*b; MULTI the same with u.
  - DIV2 a>>1; INV ~a.
  - AND a&b; OR a|b; NOR ~(a|b).
  - Default overflow/underflow handling is modulo 2^W.
- Opcodes 12..(2^OPCODE_WIDTH-1): out_pixel=a, out_err=1, latency 1. out_err=0 for all legal opcodes.
- CELL_N=1: AVG returns the single pixel after 1 cycle.

Optional Feature:
- Macro: CELL_ALU_SATURATE_EN.
- When defined:
  - ADD/ADDI/MULT/MULTI clamp to 2^W-1 on overflow.
  - SUB/SUBI clamp to 0 on underflow.
- When undefined: all arithmetic wraps modulo 2^W.
- DIV2/INV/logic/AVG are unaffected in both cases.

Test Plan:
- ADD, W=8,C=3,N=3, A centre 0x1020F0, B centre 0x010220: out_pixel 0x112210 (saturate: 0x1122FF), out_valid one cycle after accept, out_err=0.
- SUBI, A centre 0x204080, in_user 0x30: out_pixel 0xF01050 (saturate: 0x001050).
- AVG, ch0 of pixels 0..8 = 1..9, ch1 all 0xFF, ch2 all 0: out_pixel 0x00FF05, out_valid exactly 9 cycles after accept, in_ready=0 throughout.
- Backpressure: out_ready held 0 for 5 cycles after out_valid: out_pixel stable, in_ready=0. Raise out_ready: handshake, then in_ready=1 the next cycle; a back-to-back MULTI 0x102030 x 0x02 returns 0x204060.
- Illegal opcode 4'hD, A centre 0xABCDEF: out_pixel 0xABCDEF, out_err=1. Next legal INV of 0x00FF0F gives 0xFF00F0 with out_err=0.
- Reset: reset_n low during AVG accumulate cycle 4: out_valid=0 and out_pixel=0 immediately. After release in_ready=1, and a fresh ADD 0x010101+0x010101 gives 0x020202.
